// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider controller.
package div_pkg;

    localparam int DIV_WIDTH = 10;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRIME = 3'd2,
        ITER  = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/rem_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module rem_sub_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] d,
    input  logic             qlout,
    output logic [WIDTH:0]   a_next,
    output logic             qbit
);

    logic [WIDTH:0]   t_s;
    logic [WIDTH+1:0] diff_s;

    // a[WIDTH] is always 0 (A < D before each shift), so {a, qlout} equals the zero-extended shifted remainder.
    always_comb begin
        t_s    = {a[WIDTH-1:0], qlout};
        diff_s = {a, qlout} - {2'b00, d};
        qbit   = ~diff_s[WIDTH+1];
        if (qbit) begin
            a_next = diff_s[WIDTH:0];
        end else begin
            a_next = t_s;
        end
    end

endmodule

// File: rtl/restoring_div_ctrl.sv
// Restoring-division controller driving an external quotient shift register.
// Optional divide-by-zero short-cut enabled by defining DIV_ZERO_CHECK_EN.
module restoring_div_ctrl import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] divisor,
    input  logic             qlout,
    output logic             sload,
    output logic             sshl,
    output logic             serin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_r;
    div_state_e       state_s;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH:0]   a_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dz_r;
    logic [WIDTH:0]   a_next_s;
    logic             qbit_s;
    logic             zero_s;
    logic             last_iter_s;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_s = (divisor == {WIDTH{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    rem_sub_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_r),
        .d      (d_r),
        .qlout  (qlout),
        .a_next (a_next_s),
        .qbit   (qbit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = zero_s ? DONE : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:  state_s = PRIME;
            PRIME: state_s = ITER;
            ITER: begin
                if (last_iter_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ITER;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath registers: divisor, partial remainder, counter, result.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r         <= {WIDTH{1'b0}};
            a_r         <= {(WIDTH + 1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dz_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        d_r   <= divisor;
                        a_r   <= {(WIDTH + 1){1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                        dz_r  <= zero_s;
                    end
                end
                ITER: begin
                    a_r   <= a_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                DONE: begin
                    remainder_r <= a_r[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decoded from state; serin follows the step cell only while iterating.
    always_comb begin
        sload = 1'b0;
        sshl  = 1'b0;
        serin = 1'b0;
        done  = 1'b0;
        busy  = (state_r != IDLE);
        case (state_r)
            LOAD:  sload = 1'b1;
            PRIME: sshl  = 1'b1;
            ITER: begin
                sshl  = 1'b1;
                serin = qbit_s;
            end
            DONE:    done = 1'b1;
            default: begin
            end
        endcase
    end

    assign remainder = remainder_r;
    assign dz        = dz_r;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Scoreboard bench: restoring_div_ctrl driving a behavioural 10-bit Q shift register.
module tb_restoring_div_ctrl;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] divisor;
    logic         sload, sshl, serin, busy, done, dz;
    logic [W-1:0] remainder;

    logic [W-1:0] qpin;
    logic [W-1:0] q_r;
    logic         lout_r;
    int           cyc = 0;

    typedef struct {
        int quot;
        int rem;
        int dz;
        int nshl;
        int nld;
        int done_cyc;
        bit chk_q;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    restoring_div_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .divisor   (divisor),
        .qlout     (lout_r),
        .sload     (sload),
        .sshl      (sshl),
        .serin     (serin),
        .busy      (busy),
        .done      (done),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Quotient register: parallel load, shift left with serin into LSB, MSB registered onto lout.
    always @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            lout_r <= 1'b0;
        end else if (sload) begin
            q_r <= qpin;
        end else if (sshl) begin
            lout_r <= q_r[W-1];
            q_r    <= {q_r[W-2:0], serin};
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic exp_t mk(input int quot, input int rem);
        exp_t e;
        e.quot = quot; e.rem = rem; e.dz = 0;
        e.nshl = W + 1; e.nld = 1; e.done_cyc = W + 2; e.chk_q = 1'b1;
        return e;
    endfunction

    // Called at a negedge with the DUT idle; done_cyc enters as an offset from the accepting edge.
    task automatic issue(input int dvd, input int dvs, input exp_t e);
        qpin    = W'(dvd);
        divisor = W'(dvs);
        start   = 1'b1;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + e.done_cyc;
        sb.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run(input int dvd, input int dvs, input exp_t e);
        issue(dvd, dvs, e);
        wait_done();
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: count strobes, pop and compare on done, check remainder the cycle after.
    int  nshl = 0, nld = 0;
    bit  rem_pend = 1'b0;
    int  rem_exp = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                nshl = 0; nld = 0; rem_pend = 1'b0;
            end else begin
                if (rem_pend) begin
                    check("remainder", int'(remainder), rem_exp);
                    rem_pend = 1'b0;
                end
                if (sload) nld++;
                if (sshl) nshl++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_q) check("quotient", int'(q_r), e.quot);
                        check("dz", int'(dz), e.dz);
                        check("sshl_count", nshl, e.nshl);
                        check("sload_count", nld, e.nld);
                        check("done_cycle", cyc, e.done_cyc);
                        rem_pend = 1'b1;
                        rem_exp  = e.rem;
                    end
                    nshl = 0; nld = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; divisor = '0; qpin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobes", int'({sload, sshl, serin}), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dz", int'(dz), 0);
        rst = 1'b0;
        @(negedge clk);

        run(100, 7, mk(14, 2));
        run(1023, 1, mk(1023, 0));
        run(5, 9, mk(0, 5));
        run(1023, 1023, mk(1, 0));

`ifdef DIV_ZERO_CHECK_EN
        e = mk(0, 0);
        e.dz = 1; e.nshl = 0; e.nld = 0; e.done_cyc = 0; e.chk_q = 1'b0;
`else
        e = mk(1023, 37);
`endif
        run(37, 0, e);

        // Abort during the 4th ITER cycle, then a clean division.
        qpin = W'(200); divisor = W'(9); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_outputs", int'({sload, sshl, serin, done, dz}), 0);
        check("abort_remainder", int'(remainder), 0);
        rst = 1'b0;
        @(negedge clk);
        run(50, 6, mk(8, 2));

        // start with a different divisor mid-ITER must be ignored.
        issue(100, 7, mk(14, 2));
        repeat (5) @(negedge clk);
        divisor = W'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        @(negedge clk);

        // Back-to-back: second start in the first IDLE cycle after done.
        issue(200, 13, mk(15, 5));
        wait_done();
        @(negedge clk);
        issue(77, 77, mk(1, 0));
        repeat (4) @(negedge clk);
        check("remainder_hold", int'(remainder), 5);
        wait_done();
        @(negedge clk);
        @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
